// File: rtl/mem_result_packer_pkg.sv
// Shared definitions for the MEM result packer: the assembled MEM record
// layout, the packet header layout and the packer FSM states.
package mem_result_packer_pkg;

    localparam int unsigned RID_W  = 16;
    localparam int unsigned POS_W  = 32;
    localparam int unsigned QLEN_W = 16;

    // id is the last member so it sits at the LSBs of the packed record.
    typedef struct packed {
        logic [POS_W-1:0]  ref_pos;
        logic [QLEN_W-1:0] qlen;
        logic [RID_W-1:0]  id;
    } AssemMem;

    localparam int unsigned MEM_W  = $bits(AssemMem);
    localparam int unsigned PKT_W  = MEM_W + 1;
    localparam int unsigned KEEP_W = (PKT_W + 7) / 8;

    // Header layout is fixed for the default 64-deep buffer.
    localparam int unsigned DEPTH_DEFAULT = 64;
    localparam int unsigned HDR_CNT_W     = $clog2(DEPTH_DEFAULT + 1);
    localparam int unsigned HDR_PAD_W     = MEM_W - 1 - HDR_CNT_W - RID_W;

    typedef struct packed {
        logic [HDR_PAD_W-1:0] pad;
        logic                 ovf;
        logic [HDR_CNT_W-1:0] cnt;
        logic [RID_W-1:0]     id;
    } PktHdr;

    localparam logic PKT_HDR_FLAG = 1'b1;

    typedef enum logic [1:0] {
        StFill,
        StHdr,
        StDrain
    } pkt_state_e;

endpackage

// File: rtl/mem_result_packer_fifo.sv
// mem_pkt_fifo: single-clock first-word-fall-through FIFO for one read's
// records. Memory has no reset so it can map onto distributed/block RAM.
//   clk, rst  : clock, synchronous active-high reset (clears pointers)
//   i_push    : write i_wdata (ignored when full)
//   i_pop     : advance head (ignored when empty)
//   o_rdata   : current head word, valid whenever !o_empty
//   o_empty   : no words stored
//   o_full    : DEPTH words stored
module mem_pkt_fifo #(
    parameter int unsigned DEPTH = 64,
    parameter int unsigned WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_empty,
    output logic             o_full
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;
    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == (AW+1)'(DEPTH));
    assign o_rdata   = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/mem_result_packer.sv
// mem_result_packer: buffers one read's assembled MEM records, then emits a
// header beat {1, pad, ovf, cnt, rid} followed by the buffered records.
//   clk, rst              : clock, synchronous active-high reset
//   i/o_s_axis_asm_*      : record stream in; tlast marks the read's last MEM
//   o/i_m_axis_pkt_*      : packet stream out; MSB = 1 on the header beat
//   o_dropped_cnt         : saturating count of records dropped on overflow
module mem_result_packer
    import mem_result_packer_pkg::*;
#(
    parameter int unsigned DEPTH = 64,
    parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_s_axis_asm_tvalid,
    output logic              o_s_axis_asm_tready,
    input  logic [MEM_W-1:0]  i_s_axis_asm_tdata,
    input  logic              i_s_axis_asm_tlast,
    output logic              o_m_axis_pkt_tvalid,
    input  logic              i_m_axis_pkt_tready,
    output logic [PKT_W-1:0]  o_m_axis_pkt_tdata,
    output logic              o_m_axis_pkt_tlast,
    output logic [KEEP_W-1:0] o_m_axis_pkt_tstrb,
    output logic [KEEP_W-1:0] o_m_axis_pkt_tkeep,
    output logic [31:0]       o_dropped_cnt
);

    pkt_state_e       r_state;
    pkt_state_e       w_state_next;
    logic [CNT_W-1:0] r_cnt;      // records stored; counts down while draining
    logic             r_ovf;
    logic [RID_W-1:0] r_rid;
    logic [31:0]      r_dropped;

    logic             w_s_hs;
    logic             w_m_hs;
    logic             w_push;
    logic             w_pop;
    logic [MEM_W-1:0] w_fifo_rdata;
    logic             w_fifo_empty;
    logic             w_fifo_full;
    PktHdr            w_hdr;

    assign w_s_hs = (r_state == StFill) && i_s_axis_asm_tvalid;
    assign w_m_hs = o_m_axis_pkt_tvalid && i_m_axis_pkt_tready;
    // FIFO occupancy equals r_cnt while filling, so full means cnt == DEPTH.
    assign w_push = w_s_hs && !w_fifo_full;
    assign w_pop  = (r_state == StDrain) && w_m_hs;

    assign w_hdr = '{pad: '0, ovf: r_ovf, cnt: HDR_CNT_W'(r_cnt), id: r_rid};

    assign o_m_axis_pkt_tstrb = '1;
    assign o_m_axis_pkt_tkeep = '1;
    assign o_dropped_cnt      = r_dropped;

    mem_pkt_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (MEM_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_wdata (i_s_axis_asm_tdata),
        .i_pop   (w_pop),
        .o_rdata (w_fifo_rdata),
        .o_empty (w_fifo_empty),
        .o_full  (w_fifo_full)
    );

    always_comb begin
        w_state_next        = r_state;
        o_s_axis_asm_tready = 1'b0;
        o_m_axis_pkt_tvalid = 1'b0;
        o_m_axis_pkt_tdata  = '0;
        o_m_axis_pkt_tlast  = 1'b0;
        case (r_state)
            StFill: begin
                o_s_axis_asm_tready = 1'b1;
                if (w_s_hs && i_s_axis_asm_tlast) w_state_next = StHdr;
            end
            StHdr: begin
                o_m_axis_pkt_tvalid = 1'b1;
                o_m_axis_pkt_tdata  = {PKT_HDR_FLAG, w_hdr};
                o_m_axis_pkt_tlast  = (r_cnt == '0);
                if (w_m_hs) w_state_next = (r_cnt == '0) ? StFill : StDrain;
            end
            StDrain: begin
                o_m_axis_pkt_tvalid = !w_fifo_empty;
                o_m_axis_pkt_tdata  = {1'b0, w_fifo_rdata};
                o_m_axis_pkt_tlast  = (r_cnt == CNT_W'(1));
                if (w_m_hs && (r_cnt == CNT_W'(1))) w_state_next = StFill;
            end
            default: w_state_next = StFill;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= StFill;
            r_cnt     <= '0;
            r_ovf     <= 1'b0;
            r_rid     <= '0;
            r_dropped <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_s_hs) begin
                // id occupies the record's LSBs; latch it from the read's first beat.
                if (r_cnt == '0) r_rid <= i_s_axis_asm_tdata[RID_W-1:0];
                if (w_push) begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end else begin
                    r_ovf <= 1'b1;
                    if (r_dropped != '1) r_dropped <= r_dropped + 32'd1;
                end
            end
            if (w_pop) begin
                r_cnt <= r_cnt - CNT_W'(1);
                if (r_cnt == CNT_W'(1)) r_ovf <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mem_result_packer.sv
module tb_mem_result_packer;
    import mem_result_packer_pkg::*;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              s_tvalid = 1'b0;
    logic              s_tready;
    logic [MEM_W-1:0]  s_tdata = '0;
    logic              s_tlast = 1'b0;
    logic              m_tvalid;
    logic              m_tready = 1'b0;
    logic [PKT_W-1:0]  m_tdata;
    logic              m_tlast;
    logic [KEEP_W-1:0] m_tstrb;
    logic [KEEP_W-1:0] m_tkeep;
    logic [31:0]       dropped;

    int      checks = 0;
    int      errors = 0;
    longint  t_first_acc = 0;
    longint  t_last_hs = 0;
    longint  t_rd1_done = 0;

    typedef struct {
        logic [15:0] id;
        int          n;
        int          exp_cnt;
        logic        exp_ovf;
        logic [31:0] exp_drop;
    } vec_t;

    vec_t vecs [3];

    always #5 clk = ~clk;

    mem_result_packer #(.DEPTH(64)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .i_s_axis_asm_tvalid (s_tvalid),
        .o_s_axis_asm_tready (s_tready),
        .i_s_axis_asm_tdata  (s_tdata),
        .i_s_axis_asm_tlast  (s_tlast),
        .o_m_axis_pkt_tvalid (m_tvalid),
        .i_m_axis_pkt_tready (m_tready),
        .o_m_axis_pkt_tdata  (m_tdata),
        .o_m_axis_pkt_tlast  (m_tlast),
        .o_m_axis_pkt_tstrb  (m_tstrb),
        .o_m_axis_pkt_tkeep  (m_tkeep),
        .o_dropped_cnt       (dropped)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s actual=timeout required=completion", name);
    endtask

    function automatic AssemMem mk_rec(input logic [15:0] id, input int i);
        AssemMem r;
        r.ref_pos = {id, 16'(i)};
        r.qlen    = 16'(i * 3 + 1);
        r.id      = id;
        return r;
    endfunction

    // Drives n records; returns at the negedge before the last beat's handshake edge
    // has passed (keep_valid) or one negedge later with tvalid dropped.
    task automatic send(input logic [15:0] id, input int n, input bit keep_valid);
        for (int i = 0; i < n; i++) begin
            int w = 0;
            @(negedge clk);
            s_tvalid = 1'b1;
            s_tdata  = mk_rec(id, i);
            s_tlast  = (i == n - 1);
            while (!s_tready && w < 500) begin
                @(negedge clk);
                w++;
            end
            if (w >= 500) timeout("send_ready");
            if (i == 0) t_first_acc = $time;
        end
        if (!keep_valid) begin
            @(negedge clk);
            s_tvalid = 1'b0;
            s_tlast  = 1'b0;
        end
    endtask

    task automatic recv(input logic [15:0] id, input int exp_cnt, input logic exp_ovf,
                        input bit rnd, input bit chk_timing);
        int               k = 0;
        int               cyc = 0;
        bit               stall = 0;
        bit               done = 0;
        logic [PKT_W-1:0] held_d = '0;
        logic             held_l = 1'b0;
        logic [PKT_W-1:0] exp_d;
        if (chk_timing) check("hdr_latency_valid", m_tvalid, 1'b1);
        while (!done && cyc < 3000) begin
            if (stall) begin
                check("stall_valid", m_tvalid, 1'b1);
                check("stall_data", m_tdata, held_d);
                check("stall_last", m_tlast, held_l);
            end
            m_tready = rnd ? ($urandom_range(0, 99) >= 30) : 1'b1;
            stall = 0;
            if (m_tvalid) begin
                check("s_tready_blocked", s_tready, 1'b0);
                if (m_tready) begin
                    if (k == 0) exp_d = {1'b1, 40'h0, exp_ovf, 7'(exp_cnt), id};
                    else        exp_d = {1'b0, mk_rec(id, k - 1)};
                    check($sformatf("id%0h_beat%0d_data", id, k), m_tdata, exp_d);
                    check($sformatf("id%0h_beat%0d_last", id, k), m_tlast, (k == exp_cnt));
                    if (k == exp_cnt) begin
                        done = 1;
                        t_last_hs = $time;
                    end
                    k++;
                end else begin
                    stall  = 1;
                    held_d = m_tdata;
                    held_l = m_tlast;
                end
            end
            @(negedge clk);
            cyc++;
        end
        m_tready = 1'b0;
        if (!done) timeout("recv_packet");
        check($sformatf("id%0h_beat_count", id), k, exp_cnt + 1);
        check("post_pkt_idle", m_tvalid, 1'b0);
    endtask

    initial begin
        vecs[0] = '{id: 16'h002A, n: 3,  exp_cnt: 3,  exp_ovf: 1'b0, exp_drop: 32'd0};
        vecs[1] = '{id: 16'h0005, n: 1,  exp_cnt: 1,  exp_ovf: 1'b0, exp_drop: 32'd0};
        vecs[2] = '{id: 16'h0033, n: 69, exp_cnt: 64, exp_ovf: 1'b1, exp_drop: 32'd5};

        repeat (3) @(negedge clk);
        check("rst_m_tvalid", m_tvalid, 1'b0);
        check("rst_m_tlast", m_tlast, 1'b0);
        check("rst_m_tdata", m_tdata, '0);
        check("rst_s_tready", s_tready, 1'b1);
        check("rst_dropped", dropped, 32'd0);
        check("tstrb_ones", m_tstrb, 9'h1FF);
        check("tkeep_ones", m_tkeep, 9'h1FF);
        rst = 1'b0;

        for (int v = 0; v < 3; v++) begin
            send(vecs[v].id, vecs[v].n, 1'b0);
            recv(vecs[v].id, vecs[v].exp_cnt, vecs[v].exp_ovf, 1'b0, 1'b1);
            check($sformatf("vec%0d_dropped", v), dropped, vecs[v].exp_drop);
        end

        // Two reads drained against a randomly stalling sink.
        send(16'h0040, 4, 1'b0);
        recv(16'h0040, 4, 1'b0, 1'b1, 1'b1);
        send(16'h0041, 7, 1'b0);
        recv(16'h0041, 7, 1'b0, 1'b1, 1'b1);
        check("dropped_hold", dropped, 32'd5);

        // Reset after header + 2 of 5 records have been taken.
        send(16'h0011, 5, 1'b0);
        m_tready = 1'b1;
        repeat (3) @(negedge clk);
        check("mid_drain_rec2", m_tdata, {1'b0, mk_rec(16'h0011, 2)});
        rst      = 1'b1;
        m_tready = 1'b0;
        @(negedge clk);
        check("mid_rst_m_tvalid", m_tvalid, 1'b0);
        check("mid_rst_s_tready", s_tready, 1'b1);
        check("mid_rst_dropped", dropped, 32'd0);
        rst = 1'b0;
        send(16'h0044, 2, 1'b0);
        recv(16'h0044, 2, 1'b0, 1'b0, 1'b1);

        // Upstream tvalid held high straight across the read boundary.
        fork
            begin
                send(16'h0061, 3, 1'b1);
                send(16'h0062, 2, 1'b0);
            end
            begin
                recv(16'h0061, 3, 1'b0, 1'b0, 1'b0);
                t_rd1_done = t_last_hs;
                recv(16'h0062, 2, 1'b0, 1'b0, 1'b0);
            end
        join
        check("rd2_accept_after_rd1", (t_first_acc > t_rd1_done), 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
